usb_uart_bridge_fifo_ep: RTL and testbench

Parametrised successor of the single-byte USB/UART bridge endpoint. Buffers both directions in FIFOs and batches CPU-written bytes into multi-byte IN packets. An IN packet is sent when MAX_PKT bytes are queued, or when bytes have sat idle for FLUSH_TIMEOUT cycles. Sits between the USB device core's endpoint arbiter interface and the SoC UART-style byte register port.

---
 rtl/usb_uart_pkg.sv | 20 ++
 rtl/usb_uart_sync_fifo.sv | 60 ++++++
 rtl/usb_uart_bridge_fifo_ep.sv | 201 ++++++++++++++++++++
 tb/tb_usb_uart_bridge_fifo_ep.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_uart_pkg
// Purpose  : Shared types and constants for the USB/UART FIFO bridge endpoint.
//            Holds the IN-packet FSM state encoding and the byte width.
// Revision : 1.0 - initial release
// ============================================================================
package usb_uart_pkg;

    localparam int c_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } in_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : usb_uart_sync_fifo
// Purpose  : Single-clock first-word fall-through FIFO with occupancy output.
//            o_data always shows the head entry (0 when empty); a pop moves
//            the next entry onto o_data in the following cycle. Pushes into
//            a full FIFO and pops from an empty FIFO are ignored.
// Ports    : clk, rst (sync, active-high)
//            i_push/i_data  write side
//            i_pop/o_data   read side (FWFT)
//            o_full, o_empty, o_level  status
// Revision : 1.0 - initial release
// ============================================================================
module usb_uart_sync_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_level == (c_AW+1)'(DEPTH));
    assign o_empty   = (o_level == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/usb_uart_bridge_fifo_ep.sv
`default_nettype none
// ============================================================================
// Module   : usb_uart_bridge_fifo_ep
// Purpose  : USB endpoint <-> UART-style byte port bridge with FIFOs in both
//            directions. CPU-written bytes are batched into IN packets of up
//            to MAX_PKT bytes; a partial packet is flushed once the queued
//            bytes have been idle for FLUSH_TIMEOUT cycles.
// Ports    : clk, reset (sync, active-high)
//            out_ep_*  OUT endpoint arbiter interface (host -> uart)
//            in_ep_*   IN endpoint arbiter interface  (uart -> host)
//            uart_*    byte register port, uart_do is the RX FIFO head
//            tx_level, rx_level  FIFO occupancies
// Config   : `define USB_UART_ZLP_EN to send a zero-length packet after a
//            full-size packet that leaves the TX FIFO empty.
// Revision : 1.0 - initial release
// ============================================================================
module usb_uart_bridge_fifo_ep
    import usb_uart_pkg::*;
#(
    parameter int TX_DEPTH      = 32,
    parameter int RX_DEPTH      = 32,
    parameter int MAX_PKT       = 32,
    parameter int FLUSH_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      out_ep_req,
    input  logic                      out_ep_grant,
    input  logic                      out_ep_data_avail,
    input  logic                      out_ep_setup,
    output logic                      out_ep_data_get,
    input  logic [7:0]                out_ep_data,
    output logic                      out_ep_stall,
    input  logic                      out_ep_acked,
    output logic                      in_ep_req,
    input  logic                      in_ep_grant,
    input  logic                      in_ep_data_free,
    output logic                      in_ep_data_put,
    output logic [7:0]                in_ep_data,
    output logic                      in_ep_data_done,
    output logic                      in_ep_stall,
    input  logic                      in_ep_acked,
    input  logic                      uart_we,
    input  logic                      uart_re,
    input  logic [7:0]                uart_di,
    output logic [7:0]                uart_do,
    output logic                      uart_wait,
    output logic [$clog2(TX_DEPTH):0] tx_level,
    output logic [$clog2(RX_DEPTH):0] rx_level
);

    localparam int c_CW  = $clog2(MAX_PKT) + 1;
    localparam int c_TLW = $clog2(TX_DEPTH) + 1;
    localparam int c_RLW = $clog2(RX_DEPTH) + 1;
    localparam int c_TW  = $clog2(FLUSH_TIMEOUT + 1);

    logic                w_tx_full, w_tx_empty, w_tx_push;
    logic [c_BYTE_W-1:0] w_tx_head;
    logic                w_rx_full, w_rx_empty, w_rx_pop;
    logic [c_RLW-1:0]    w_rx_free;
    logic                w_get, r_inflight;
    logic [c_TW-1:0]     r_timer, w_timer_next;
    logic                w_flush;
    in_state_t           r_state, w_state_next;
    logic [c_CW-1:0]     r_sent, r_pkt_len, w_pkt_min;
    logic                r_zlp, w_latch, w_zlp_start, w_relatch, w_put, w_done;
    logic                w_unused;

    assign w_unused = &{1'b0, out_ep_setup, out_ep_acked, in_ep_acked, w_rx_full};

    // ---------------- byte port ----------------
    assign w_tx_push = uart_we & ~w_tx_full;
    assign w_rx_pop  = uart_re & ~w_rx_empty;
    assign uart_wait = (uart_we & w_tx_full) | (uart_re & w_rx_empty);

    usb_uart_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(c_BYTE_W)) u_tx_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_tx_push),
        .i_data  (uart_di),
        .i_pop   (w_put),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_level (tx_level)
    );

    usb_uart_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(c_BYTE_W)) u_rx_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (r_inflight),
        .i_data  (out_ep_data),
        .i_pop   (w_rx_pop),
        .o_data  (uart_do),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_level (rx_level)
    );

    // ---------------- OUT path ----------------
    // A byte fetched last cycle is not yet counted in rx_level, so it must be
    // reserved before another get is issued; this guarantees no drop.
    assign out_ep_req      = out_ep_data_avail;
    assign out_ep_stall    = 1'b0;
    assign w_rx_free       = c_RLW'(RX_DEPTH) - rx_level;
    assign w_get           = ~reset & out_ep_grant & out_ep_data_avail &
                             (w_rx_free > {{(c_RLW-1){1'b0}}, r_inflight});
    assign out_ep_data_get = w_get;

    always_ff @(posedge clk) begin
        if (reset) r_inflight <= 1'b0;
        else       r_inflight <= w_get;
    end

    // ---------------- idle flush timer ----------------
    always_comb begin
        w_timer_next = r_timer;
        if (w_tx_push || (r_state != ST_IDLE))
            w_timer_next = '0;
        else if (!w_tx_empty && (r_timer != c_TW'(FLUSH_TIMEOUT)))
            w_timer_next = r_timer + 1'b1;
    end

    // Flush decision uses the incremented value so REQ follows the last write
    // by exactly FLUSH_TIMEOUT cycles.
    assign w_flush = (w_timer_next == c_TW'(FLUSH_TIMEOUT)) & ~w_tx_empty;

    always_ff @(posedge clk) begin
        if (reset) r_timer <= '0;
        else       r_timer <= w_timer_next;
    end

    // ---------------- IN packet FSM ----------------
    assign w_pkt_min = (tx_level >= c_TLW'(MAX_PKT)) ? c_CW'(MAX_PKT) : c_CW'(tx_level);
    // A pending ZLP turns into a normal packet if bytes arrive before grant.
    assign w_relatch = (r_state == ST_REQ) & r_zlp & ~w_tx_empty;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_zlp_start  = 1'b0;
        w_put        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((tx_level >= c_TLW'(MAX_PKT)) || w_flush) begin
                    w_state_next = ST_REQ;
                    w_latch      = 1'b1;
                end
            end
            ST_REQ: begin
                if (in_ep_grant && in_ep_data_free) w_state_next = ST_SEND;
            end
            ST_SEND: begin
                w_put = in_ep_data_free & in_ep_grant & (r_sent < r_pkt_len);
                if (r_sent == r_pkt_len) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
`ifdef USB_UART_ZLP_EN
                if ((r_pkt_len == c_CW'(MAX_PKT)) && w_tx_empty) begin
                    w_state_next = ST_REQ;
                    w_zlp_start  = 1'b1;
                end
`endif
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sent    <= '0;
            r_pkt_len <= '0;
            r_zlp     <= 1'b0;
        end else begin
            r_sent <= (r_state == ST_SEND) ? (r_sent + c_CW'(w_put)) : '0;
            if (w_latch || w_relatch) begin
                r_pkt_len <= w_pkt_min;
                r_zlp     <= 1'b0;
            end else if (w_zlp_start) begin
                r_pkt_len <= '0;
                r_zlp     <= 1'b1;
            end
        end
    end

    assign in_ep_req       = (r_state != ST_IDLE);
    assign in_ep_data_put  = w_put;
    assign in_ep_data      = w_put ? w_tx_head : 8'h00;
    assign in_ep_data_done = w_done;
    assign in_ep_stall     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_usb_uart_bridge_fifo_ep.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_uart_bridge_fifo_ep
// Purpose  : Self-checking bench for usb_uart_bridge_fifo_ep. Stimulus pushes
//            expected IN bytes / packet lengths / RX bytes into queues; a
//            monitor pops and compares whenever the DUT presents data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_uart_bridge_fifo_ep;

    localparam int TXD = 32;
    localparam int RXD = 32;
    localparam int MP  = 32;
    localparam int FT  = 16;
`ifdef USB_UART_ZLP_EN
    localparam bit ZLP = 1'b1;
`else
    localparam bit ZLP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       out_ep_req, out_ep_grant, out_ep_data_avail, out_ep_setup;
    logic       out_ep_data_get, out_ep_stall, out_ep_acked;
    logic [7:0] out_ep_data;
    logic       in_ep_req, in_ep_grant, in_ep_data_free, in_ep_data_put;
    logic       in_ep_data_done, in_ep_stall, in_ep_acked;
    logic [7:0] in_ep_data;
    logic       uart_we, uart_re, uart_wait;
    logic [7:0] uart_di, uart_do;
    logic [5:0] tx_level, rx_level;

    usb_uart_bridge_fifo_ep #(
        .TX_DEPTH(TXD), .RX_DEPTH(RXD), .MAX_PKT(MP), .FLUSH_TIMEOUT(FT)
    ) dut (
        .clk(clk), .reset(reset),
        .out_ep_req(out_ep_req), .out_ep_grant(out_ep_grant),
        .out_ep_data_avail(out_ep_data_avail), .out_ep_setup(out_ep_setup),
        .out_ep_data_get(out_ep_data_get), .out_ep_data(out_ep_data),
        .out_ep_stall(out_ep_stall), .out_ep_acked(out_ep_acked),
        .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
        .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
        .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
        .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
        .uart_we(uart_we), .uart_re(uart_re), .uart_di(uart_di),
        .uart_do(uart_do), .uart_wait(uart_wait),
        .tx_level(tx_level), .rx_level(rx_level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_in[$];
    int         exp_len[$];
    logic [7:0] exp_rx[$];
    logic [7:0] host_q[$];
    int cur_puts = 0;
    int done_cnt = 0;
    int rd_cnt   = 0;
    int exp_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected DUT output, nothing queued", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] v);
        uart_we = 1'b1;
        uart_di = v;
        tick();
        uart_we = 1'b0;
    endtask

    // Queue one expected IN packet (plus the trailing ZLP when enabled).
    task automatic expect_pkt(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) exp_in.push_back(base + 8'(i));
        exp_len.push_back(n);
        exp_done++;
        if (ZLP && n == MP) begin
            exp_len.push_back(0);
            exp_done++;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt < exp_done && n < budget) begin
            tick();
            n++;
        end
        chk("done_count", done_cnt, exp_done);
    endtask

    // Monitor: pops the scoreboard queues whenever the DUT presents data.
    initial begin
        forever begin
            @(negedge clk);
            if (in_ep_data_put) begin
                if (exp_in.size() == 0) fail("in_extra_put");
                else chk("in_data", in_ep_data, exp_in.pop_front());
                cur_puts++;
            end
            if (in_ep_data_done) begin
                done_cnt++;
                if (exp_len.size() == 0) fail("in_extra_done");
                else chk("in_pkt_len", cur_puts, exp_len.pop_front());
                cur_puts = 0;
            end
            if (uart_re && !uart_wait) begin
                if (exp_rx.size() == 0) fail("rx_extra_read");
                else chk("uart_do", uart_do, exp_rx.pop_front());
                rd_cnt++;
            end
        end
    end

    // Host OUT endpoint model: byte appears the cycle after get.
    initial begin
        logic g;
        out_ep_data_avail = 1'b0;
        out_ep_data       = 8'h00;
        forever begin
            @(negedge clk);
            g = out_ep_data_get;
            @(posedge clk);
            #1;
            if (g && host_q.size() > 0) out_ep_data = host_q.pop_front();
            out_ep_data_avail = (host_q.size() > 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; uart_we = 1'b0; uart_re = 1'b0; uart_di = 8'h00;
        out_ep_grant = 1'b1; out_ep_setup = 1'b0; out_ep_acked = 1'b0;
        in_ep_grant = 1'b1; in_ep_data_free = 1'b1; in_ep_acked = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_in_req", in_ep_req, 0);
        chk("rst_get", out_ep_data_get, 0);
        chk("rst_stalls", {out_ep_stall, in_ep_stall}, 0);
        chk("rst_uart_do", uart_do, 0);
        reset = 1'b0;
        tick();

        // Full packet: 32 bytes back-to-back, sent without timer wait
        expect_pkt(8'h00, 32);
        for (int i = 0; i < 32; i++) write_byte(8'(i));
        chk("full_tx_level", tx_level, 32);
        tick();
        chk("full_req_immediate", in_ep_req, 1);
        wait_done(200);
        chk("full_tx_empty", tx_level, 0);
        repeat (40) tick();
        chk("no_extra_pkt", done_cnt, exp_done);

        // Partial packet flushed by idle timer
        expect_pkt(8'hA0, 5);
        for (int i = 0; i < 5; i++) write_byte(8'hA0 + 8'(i));
        chk("part_tx_level", tx_level, 5);
        n = 0;
        while (!in_ep_req && n < 100) begin
            tick();
            n++;
        end
        chk("flush_delay", n, FT);
        wait_done(100);

        // Free drops for 3 cycles mid-SEND
        expect_pkt(8'h40, 32);
        for (int i = 0; i < 32; i++) write_byte(8'h40 + 8'(i));
        n = 0;
        while (cur_puts < 10 && n < 100) begin
            tick();
            n++;
        end
        in_ep_data_free = 1'b0;
        repeat (3) begin
            #1;
            chk("pause_no_put", in_ep_data_put, 0);
            tick();
        end
        in_ep_data_free = 1'b1;
        wait_done(200);

        // uart_wait on empty RX read and full TX write
        uart_re = 1'b1;
        #1;
        chk("wait_rx_empty", uart_wait, 1);
        tick();
        uart_re = 1'b0;
        chk("rx_no_pop", rx_level, 0);
        in_ep_data_free = 1'b0;
        for (int i = 0; i < 32; i++) write_byte(8'h10 + 8'(i));
        uart_we = 1'b1;
        uart_di = 8'hEE;
        #1;
        chk("wait_tx_full", uart_wait, 1);
        tick();
        uart_we = 1'b0;
        chk("tx_full_level", tx_level, 32);
        expect_pkt(8'h10, 32);
        in_ep_data_free = 1'b1;
        wait_done(200);

        // OUT path: 40 bytes into a 32-deep RX FIFO, then read all
        for (int i = 0; i < 40; i++) begin
            host_q.push_back(8'h80 + 8'(i));
            exp_rx.push_back(8'h80 + 8'(i));
        end
        n = 0;
        while (rx_level != 32 && n < 200) begin
            tick();
            n++;
        end
        repeat (10) tick();
        chk("rx_level_cap", rx_level, 32);
        chk("rx_get_low", out_ep_data_get, 0);
        chk("host_left", host_q.size(), 8);
        uart_re = 1'b1;
        n = 0;
        while (rd_cnt < 40 && n < 400) begin
            tick();
            n++;
        end
        uart_re = 1'b0;
        chk("rx_read_count", rd_cnt, 40);
        chk("rx_all_consumed", exp_rx.size(), 0);

        // Reset mid-SEND: no done pulse, FIFOs emptied
        for (int i = 0; i < 32; i++) begin
            exp_in.push_back(8'h60 + 8'(i));
            write_byte(8'h60 + 8'(i));
        end
        n = 0;
        while (cur_puts < 8 && n < 100) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        exp_in.delete();
        cur_puts = 0;
        tick();
        reset = 1'b0;
        chk("rst_mid_tx_level", tx_level, 0);
        chk("rst_mid_req", in_ep_req, 0);
        repeat (60) tick();
        chk("rst_mid_no_done", done_cnt, exp_done);
        chk("rst_mid_no_put", cur_puts, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
